// File: rtl/mem_str_fwd_unit_if.sv
// Bus bundle for mem_str_fwd_unit: pipeline control, two-lane writeback,
// store operands, and the registered store word returned to the MEM stage.
//   master : drives stall/flush, wb_* and str_*; observes mem_data/valid/hits
//   slave  : the forwarding unit itself
interface mem_str_fwd_unit_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TOP_W  = 4,
    parameter int unsigned ADDR_W = 5
);
    logic                    stall;
    logic                    flush;
    logic                    wb_valid_top;
    logic [ADDR_W-1:0]       wb_addr_top;
    logic [DATA_W-1:0]       wb_data_top;
    logic                    wb_valid_bot;
    logic [ADDR_W-1:0]       wb_addr_bot;
    logic [DATA_W-1:0]       wb_data_bot;
    logic                    str_valid;
    logic [ADDR_W-1:0]       str_addr_top;
    logic [DATA_W-1:0]       str_data_top;
    logic [ADDR_W-1:0]       str_addr_bot;
    logic [DATA_W-1:0]       str_data_bot;
    logic [TOP_W+DATA_W-1:0] mem_data;
    logic                    mem_data_valid;
    logic                    fwd_hit_top;
    logic                    fwd_hit_bot;

    modport master (
        output stall, flush,
        output wb_valid_top, wb_addr_top, wb_data_top,
        output wb_valid_bot, wb_addr_bot, wb_data_bot,
        output str_valid, str_addr_top, str_data_top, str_addr_bot, str_data_bot,
        input  mem_data, mem_data_valid, fwd_hit_top, fwd_hit_bot
    );

    modport slave (
        input  stall, flush,
        input  wb_valid_top, wb_addr_top, wb_data_top,
        input  wb_valid_bot, wb_addr_bot, wb_data_bot,
        input  str_valid, str_addr_top, str_data_top, str_addr_bot, str_data_bot,
        output mem_data, mem_data_valid, fwd_hit_top, fwd_hit_bot
    );
endinterface

// File: rtl/mem_str_fwd_unit.sv
// MEM-stage store-data forwarding unit. Keeps NUM_WB cycles of two-lane
// writeback history and forwards the youngest matching writeback (live lanes
// first, then history) into each field of the store word, one cycle later.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mem_str_fwd_unit_if.slave (control, writeback, store, outputs)
module mem_str_fwd_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TOP_W  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_WB = 2
) (
    input logic              clock,
    input logic              reset_n,
    mem_str_fwd_unit_if.slave bus
);

    logic [NUM_WB-1:0]             hist_vld_top_q,  hist_vld_top_d;
    logic [NUM_WB-1:0][ADDR_W-1:0] hist_addr_top_q, hist_addr_top_d;
    logic [NUM_WB-1:0][DATA_W-1:0] hist_data_top_q, hist_data_top_d;
    logic [NUM_WB-1:0]             hist_vld_bot_q,  hist_vld_bot_d;
    logic [NUM_WB-1:0][ADDR_W-1:0] hist_addr_bot_q, hist_addr_bot_d;
    logic [NUM_WB-1:0][DATA_W-1:0] hist_data_bot_q, hist_data_bot_d;

    logic [TOP_W+DATA_W-1:0] mem_data_q, mem_data_d;
    logic                    mem_data_valid_q, mem_data_valid_d;
    logic                    fwd_hit_top_q, fwd_hit_top_d;
    logic                    fwd_hit_bot_q, fwd_hit_bot_d;

    logic [TOP_W-1:0]  sel_top;
    logic [DATA_W-1:0] sel_bot;
    logic              hit_top;
    logic              hit_bot;

    // Candidates are scanned oldest to youngest so a later match overrides an
    // earlier one; within a cycle the bottom lane is scanned after the top.
    always_comb begin
        int unsigned k;
        sel_top = bus.str_data_top[TOP_W-1:0];
        sel_bot = bus.str_data_bot;
        hit_top = 1'b0;
        hit_bot = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            k = NUM_WB - 1 - i;
            if (hist_vld_top_q[k] && hist_addr_top_q[k] == bus.str_addr_top) begin
                hit_top = 1'b1;
                sel_top = hist_data_top_q[k][TOP_W-1:0];
            end
            if (hist_vld_bot_q[k] && hist_addr_bot_q[k] == bus.str_addr_top) begin
                hit_top = 1'b1;
                sel_top = hist_data_bot_q[k][TOP_W-1:0];
            end
            if (hist_vld_top_q[k] && hist_addr_top_q[k] == bus.str_addr_bot) begin
                hit_bot = 1'b1;
                sel_bot = hist_data_top_q[k];
            end
            if (hist_vld_bot_q[k] && hist_addr_bot_q[k] == bus.str_addr_bot) begin
                hit_bot = 1'b1;
                sel_bot = hist_data_bot_q[k];
            end
        end
        if (bus.wb_valid_top && bus.wb_addr_top == bus.str_addr_top) begin
            hit_top = 1'b1;
            sel_top = bus.wb_data_top[TOP_W-1:0];
        end
        if (bus.wb_valid_bot && bus.wb_addr_bot == bus.str_addr_top) begin
            hit_top = 1'b1;
            sel_top = bus.wb_data_bot[TOP_W-1:0];
        end
        if (bus.wb_valid_top && bus.wb_addr_top == bus.str_addr_bot) begin
            hit_bot = 1'b1;
            sel_bot = bus.wb_data_top;
        end
        if (bus.wb_valid_bot && bus.wb_addr_bot == bus.str_addr_bot) begin
            hit_bot = 1'b1;
            sel_bot = bus.wb_data_bot;
        end
        // Register 0 is hardwired; it never forwards.
        if (bus.str_addr_top == '0) begin
            hit_top = 1'b0;
            sel_top = bus.str_data_top[TOP_W-1:0];
        end
        if (bus.str_addr_bot == '0) begin
            hit_bot = 1'b0;
            sel_bot = bus.str_data_bot;
        end
    end

    always_comb begin
        hist_vld_top_d   = hist_vld_top_q;
        hist_addr_top_d  = hist_addr_top_q;
        hist_data_top_d  = hist_data_top_q;
        hist_vld_bot_d   = hist_vld_bot_q;
        hist_addr_bot_d  = hist_addr_bot_q;
        hist_data_bot_d  = hist_data_bot_q;
        mem_data_d       = mem_data_q;
        mem_data_valid_d = mem_data_valid_q;
        fwd_hit_top_d    = fwd_hit_top_q;
        fwd_hit_bot_d    = fwd_hit_bot_q;
        if (bus.flush) begin
            hist_vld_top_d   = '0;
            hist_vld_bot_d   = '0;
            mem_data_valid_d = 1'b0;
            fwd_hit_top_d    = 1'b0;
            fwd_hit_bot_d    = 1'b0;
        end else if (!bus.stall) begin
            for (int unsigned k = 1; k < NUM_WB; k++) begin
                hist_vld_top_d[k]  = hist_vld_top_q[k-1];
                hist_addr_top_d[k] = hist_addr_top_q[k-1];
                hist_data_top_d[k] = hist_data_top_q[k-1];
                hist_vld_bot_d[k]  = hist_vld_bot_q[k-1];
                hist_addr_bot_d[k] = hist_addr_bot_q[k-1];
                hist_data_bot_d[k] = hist_data_bot_q[k-1];
            end
            hist_vld_top_d[0]  = bus.wb_valid_top;
            hist_addr_top_d[0] = bus.wb_addr_top;
            hist_data_top_d[0] = bus.wb_data_top;
            hist_vld_bot_d[0]  = bus.wb_valid_bot;
            hist_addr_bot_d[0] = bus.wb_addr_bot;
            hist_data_bot_d[0] = bus.wb_data_bot;
            mem_data_valid_d   = bus.str_valid;
            if (bus.str_valid) begin
                mem_data_d    = {sel_top, sel_bot};
                fwd_hit_top_d = hit_top;
                fwd_hit_bot_d = hit_bot;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_vld_top_q   <= '0;
            hist_addr_top_q  <= '0;
            hist_data_top_q  <= '0;
            hist_vld_bot_q   <= '0;
            hist_addr_bot_q  <= '0;
            hist_data_bot_q  <= '0;
            mem_data_q       <= '0;
            mem_data_valid_q <= 1'b0;
            fwd_hit_top_q    <= 1'b0;
            fwd_hit_bot_q    <= 1'b0;
        end else begin
            hist_vld_top_q   <= hist_vld_top_d;
            hist_addr_top_q  <= hist_addr_top_d;
            hist_data_top_q  <= hist_data_top_d;
            hist_vld_bot_q   <= hist_vld_bot_d;
            hist_addr_bot_q  <= hist_addr_bot_d;
            hist_data_bot_q  <= hist_data_bot_d;
            mem_data_q       <= mem_data_d;
            mem_data_valid_q <= mem_data_valid_d;
            fwd_hit_top_q    <= fwd_hit_top_d;
            fwd_hit_bot_q    <= fwd_hit_bot_d;
        end
    end

    assign bus.mem_data       = mem_data_q;
    assign bus.mem_data_valid = mem_data_valid_q;
    assign bus.fwd_hit_top    = fwd_hit_top_q;
    assign bus.fwd_hit_bot    = fwd_hit_bot_q;

endmodule

// File: tb/tb_mem_str_fwd_unit.sv
// Directed vector bench for mem_str_fwd_unit (DATA_W=8, TOP_W=4, ADDR_W=5,
// NUM_WB=2). Vectors are applied in order; history carries between them.
module tb_mem_str_fwd_unit;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    mem_str_fwd_unit_if #(.DATA_W(8), .TOP_W(4), .ADDR_W(5)) bus ();

    mem_str_fwd_unit #(.DATA_W(8), .TOP_W(4), .ADDR_W(5), .NUM_WB(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        st, fl;
        logic        wvt; logic [4:0] wat; logic [7:0] wdt;
        logic        wvb; logic [4:0] wab; logic [7:0] wdb;
        logic        sv;
        logic [4:0]  sat; logic [7:0] sdt;
        logic [4:0]  sab; logic [7:0] sdb;
        logic [11:0] md;
        logic        v, ht, hb;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(int st, int fl, int wvt, int wat, int wdt,
                                int wvb, int wab, int wdb, int sv, int sat,
                                int sdt, int sab, int sdb, int md, int v,
                                int ht, int hb);
        vec_t r;
        r.st = 1'(st);   r.fl = 1'(fl);
        r.wvt = 1'(wvt); r.wat = 5'(wat); r.wdt = 8'(wdt);
        r.wvb = 1'(wvb); r.wab = 5'(wab); r.wdb = 8'(wdb);
        r.sv = 1'(sv);
        r.sat = 5'(sat); r.sdt = 8'(sdt);
        r.sab = 5'(sab); r.sdb = 8'(sdb);
        r.md = 12'(md);  r.v = 1'(v); r.ht = 1'(ht); r.hb = 1'(hb);
        return r;
    endfunction

    task automatic drive(input vec_t t);
        bus.stall        = t.st;
        bus.flush        = t.fl;
        bus.wb_valid_top = t.wvt; bus.wb_addr_top = t.wat; bus.wb_data_top = t.wdt;
        bus.wb_valid_bot = t.wvb; bus.wb_addr_bot = t.wab; bus.wb_data_bot = t.wdb;
        bus.str_valid    = t.sv;
        bus.str_addr_top = t.sat; bus.str_data_top = t.sdt;
        bus.str_addr_bot = t.sab; bus.str_data_bot = t.sdb;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [11:0] md, input logic v,
                           input logic ht, input logic hb);
        chk({tag, " mem_data"},       32'(bus.mem_data),       32'(md));
        chk({tag, " mem_data_valid"}, 32'(bus.mem_data_valid), 32'(v));
        chk({tag, " fwd_hit_top"},    32'(bus.fwd_hit_top),    32'(ht));
        chk({tag, " fwd_hit_bot"},    32'(bus.fwd_hit_bot),    32'(hb));
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //          st fl  wvt wat wdt    wvb wab wdb    sv sat sdt    sab sdb    md     v ht hb
        vecs[0]  = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 3,  'hA5, 4,  'h3C, 'h53C, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,  'h00, 1, 4,  'h77, 1, 3,  'hA5, 4,  'h3C, 'h577, 1, 0, 1);
        vecs[2]  = mk(0, 0, 1, 6,  'h11, 1, 6,  'h22, 0, 0,  'h00, 0,  'h00, 'h577, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 6,  'hFF, 4,  'h00, 'h277, 1, 1, 1);
        vecs[4]  = mk(0, 0, 0, 0,  'h00, 1, 9,  'hEE, 0, 0,  'h00, 0,  'h00, 'h277, 0, 1, 1);
        vecs[5]  = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 0,  'h34, 9,  'h10, 'h4EE, 1, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 2,  'h5A, 9,  'h10, 'hAEE, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 2,  'h5A, 9,  'h10, 'hA10, 1, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0,  'h99, 1, 0,  'h88, 1, 0,  'h07, 0,  'h66, 'h766, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 0,  'h0C, 0,  'h21, 'hC21, 1, 0, 0);
        vecs[10] = mk(0, 0, 1, 7,  'h3F, 1, 8,  'h55, 1, 7,  'h00, 7,  'h00, 'hF3F, 1, 1, 1);
        vecs[11] = mk(0, 0, 0, 0,  'h00, 1, 7,  'h81, 1, 7,  'h00, 8,  'h00, 'h155, 1, 1, 1);
        vecs[12] = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 8,  'h00, 7,  'h00, 'h581, 1, 1, 1);
        vecs[13] = mk(0, 0, 0, 0,  'h00, 1, 12, 'hC3, 1, 1,  'h0B, 2,  'h44, 'hB44, 1, 0, 0);
        vecs[14] = mk(1, 0, 0, 0,  'h00, 1, 12, 'h01, 1, 12, 'h00, 12, 'h00, 'hB44, 1, 0, 0);
        vecs[15] = mk(1, 0, 0, 0,  'h00, 1, 12, 'h01, 1, 12, 'h00, 12, 'h00, 'hB44, 1, 0, 0);
        vecs[16] = mk(1, 0, 0, 0,  'h00, 1, 12, 'h01, 1, 12, 'h00, 12, 'h00, 'hB44, 1, 0, 0);
        vecs[17] = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 12, 'h00, 12, 'h00, 'h3C3, 1, 1, 1);
        vecs[18] = mk(1, 1, 0, 0,  'h00, 1, 12, 'h02, 1, 12, 'h00, 12, 'h00, 'h3C3, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 1, 12, 'h06, 12, 'h07, 'h607, 1, 0, 0);
        vecs[20] = mk(0, 0, 0, 0,  'h00, 0, 0,  'h00, 0, 0,  'h00, 0,  'h00, 'h607, 0, 0, 0);

        reset_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (3) step();
        chk_out("reset", 12'h000, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].md, vecs[i].v, vecs[i].ht, vecs[i].hb);
        end

        // Capture with a writeback, then pull reset mid-cycle.
        drive(mk(0,0, 0,0,0, 1,5,'h99, 1,3,'h12,4,'h34, 0,0,0,0));
        step();
        chk_out("pre_rst", 12'h234, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("async_rst", 12'h000, 1'b0, 1'b0, 1'b0);

        // First capture after reset must not see the pre-reset writeback to r5.
        drive(mk(0,0, 0,0,0, 0,0,0, 1,5,'h02,5,'h01, 0,0,0,0));
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk_out("post_rst", 12'h201, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
